ps2_kb_rx: RTL and testbench
============================

// Module: ps2_kb_rx
// PURPOSE
//  PS/2 keyboard receiver feeding the keyboard side of the kb/screen device driver. Deserialises
//  11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) into scan-code bytes.
//  Buffers them in a small FIFO and hands each byte to the driver over its write_en/write_ok handshake.
//  Single clock domain (clk); ps2_clk/ps2_data are asynchronous pad inputs.
// PARAMETERS
//  FIFO_DEPTH   4       scan-code buffer entries, power of 2, >=2
//  FILT_LEN     8       consecutive equal samples needed to accept a ps2_clk level change
//  TIMEOUT_CYC  50000   clk cycles without a ps2_clk fall mid-frame before the frame is aborted
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  ps2_clk      in   1  PS/2 clock pad (async, open-drain, idle high)
//  ps2_data     in   1  PS/2 data pad (async)
//  data_bus_o   out  8  byte presented to driver (drives its data_bus_i)
//  write_en_o   out  1  byte valid request (drives driver control_i[1])
//  write_ok_i   in   1  driver ready/ack (from driver control_o[0]); 0 = byte taken, 1 = ready
//  frame_err_o  out  1  one-cycle pulse: parity error, bad start/stop, or timeout
//  ovf_o        out  1  sticky: a good frame arrived while FIFO full; cleared only by rst
//  fifo_cnt_o   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): all outputs 0, FIFO empty, both FSMs idle, filter state = high.
//  Input path: 2-flop synchroniser on each pad; filtered clock level toggles only after FILT_LEN
//   equal samples; a filtered 1->0 transition = "fall", sampling synchronised ps2_data that cycle.
//   Frame latency: good byte enters FIFO the cycle after the stop-bit fall.
//  RX FSM: IDLE -fall & data=0-> DATA (fall & data=1 in IDLE: ignored, frame_err pulse);
//   DATA: shift in 8 bits LSB-first -> PARITY; PARITY: store bit -> STOP;
//   STOP: on fall, if data=1 and (^byte ^ parity)=1 push byte, else frame_err; -> IDLE.
//   Timeout counter resets on every fall, runs in DATA/PARITY/STOP; reaching TIMEOUT_CYC
//   -> IDLE, frame_err pulse, partial byte discarded.
//  FIFO: push on good frame; full -> byte dropped, ovf_o set, contents unchanged.
//   Push and pop in the same cycle allowed at any occupancy (full: pop first, push accepted).
//  TX handshake FSM to driver:
//   H_IDLE: FIFO non-empty & write_ok_i=1 -> pop, load data_bus_o, write_en_o=1 next cycle -> H_REQ.
//   H_REQ: hold write_en_o=1, data_bus_o stable until write_ok_i=0 -> write_en_o=0 -> H_WAIT.
//   H_WAIT: wait write_ok_i=1 -> H_IDLE. Min 3 cycles per byte; no byte issued twice.
//   data_bus_o holds last value while idle.
//  rst mid-frame or mid-handshake: frame discarded, FIFO flushed, write_en_o drops next cycle.
// STRUCTURE
//  kb_defs.vh: RX state codes (IDLE/DATA/PARITY/STOP), handshake codes (H_IDLE/H_REQ/H_WAIT),
//   PS/2 frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8).
//  One sub-module: byte_fifo (sync, width 8, depth FIFO_DEPTH, count output, push/pop/full/empty).
//  Top holds synchroniser, filter, RX FSM, timeout counter, handshake FSM.
// TESTING
//  1. Frame 0x1C, parity 0, stop 1; write_ok_i=1 -> write_en_o rises, data_bus_o=0x1C;
//     drop write_ok_i -> write_en_o falls next cycle; fifo_cnt_o returns 0.
//  2. Frame 0x1C with parity 1 -> frame_err_o one pulse, no write_en_o, fifo_cnt_o stays 0.
//  3. write_ok_i held 0; send 0x15,0x1D,0x24,0x2D,0x2C -> fifo_cnt_o=4, ovf_o=1;
//     release write_ok_i -> bytes 0x15,0x1D,0x24,0x2D delivered in order, 0x2C lost.
//  4. Start + 4 data bits then ps2_clk held high TIMEOUT_CYC cycles -> frame_err_o pulse, RX idle;
//     following clean frame 0x5A delivered correctly.
//  5. ps2_clk glitch low for FILT_LEN-1 cycles during IDLE -> no fall, no frame_err_o.
//  6. rst asserted in H_REQ with 2 bytes queued -> write_en_o=0, fifo_cnt_o=0, ovf_o=0 next cycle.

Source files
------------

// File: rtl/ps2_kb_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
// State encodings, frame constants and the parity helper.
package ps2_kb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_REQ,
        H_WAIT
    } hs_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Odd parity holds when data plus parity bit has an odd count of ones.
    function automatic logic odd_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_kb_rx_byte_fifo.sv
// Synchronous byte FIFO with occupancy count.
// Pop is applied before push, so a full FIFO accepts a push when popped.
module ps2_kb_rx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 wdata,
    output logic [7:0]                 rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: pad sync, clock filter, frame FSM,
// scan-code FIFO and write_en/write_ok handshake to the driver.
module ps2_kb_rx
    import ps2_kb_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    data_bus_o,
    output logic                          write_en_o,
    input  logic                          write_ok_i,
    output logic                          frame_err_o,
    output logic                          ovf_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_s;
    logic [1:0]    dat_s;
    logic          level;
    logic [FW-1:0] fcnt;
    logic          fall;
    logic          sdata;

    rx_state_t     rx_st;
    logic [7:0]    sh;
    logic [2:0]    bcnt;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          tmo;

    hs_state_t     hs_st;
    logic          push;
    logic          pop;
    logic [7:0]    rdata;
    logic          full;
    logic          empty;

    // A level change is only accepted after FILT_LEN consecutive samples.
    assign fall  = level && !clk_s[1] && (fcnt == FW'(FILT_LEN - 1));
    assign sdata = dat_s[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
            level <= 1'b1;
            fcnt  <= '0;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
            if (clk_s[1] == level) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILT_LEN - 1)) begin
                level <= ~level;
                fcnt  <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign tmo  = (rx_st != IDLE) && !fall
               && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign push = fall && (rx_st == STOP)
               && (sdata == STOP_BIT) && odd_ok(sh, par);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st       <= IDLE;
            sh          <= '0;
            bcnt        <= '0;
            par         <= 1'b0;
            tcnt        <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (rx_st != IDLE && !fall) tcnt <= tcnt + 1'b1;
            else                        tcnt <= '0;
            unique case (rx_st)
                IDLE: if (fall) begin
                    if (sdata == START_BIT) begin
                        rx_st <= DATA;
                        bcnt  <= '0;
                    end else begin
                        frame_err_o <= 1'b1;
                    end
                end
                DATA: if (fall) begin
                    sh   <= {sdata, sh[7:1]};
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == 3'(DATA_BITS - 1)) rx_st <= PARITY;
                end
                PARITY: if (fall) begin
                    par   <= sdata;
                    rx_st <= STOP;
                end
                STOP: if (fall) begin
                    rx_st <= IDLE;
                    if (!push) frame_err_o <= 1'b1;
                end
                default: rx_st <= IDLE;
            endcase
            if (tmo) begin
                rx_st       <= IDLE;
                frame_err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                        ovf_o <= 1'b0;
        else if (push && full && !pop)  ovf_o <= 1'b1;
    end

    ps2_kb_rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (sh),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt_o)
    );

    assign pop = (hs_st == H_IDLE) && !empty && write_ok_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_st      <= H_IDLE;
            write_en_o <= 1'b0;
            data_bus_o <= '0;
        end else begin
            unique case (hs_st)
                H_IDLE: if (pop) begin
                    data_bus_o <= rdata;
                    write_en_o <= 1'b1;
                    hs_st      <= H_REQ;
                end
                H_REQ: if (!write_ok_i) begin
                    write_en_o <= 1'b0;
                    hs_st      <= H_WAIT;
                end
                H_WAIT: if (write_ok_i) hs_st <= H_IDLE;
                default: hs_st <= H_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: frames, parity, overflow,
// timeout, glitch filter and reset during a handshake.
module tb_ps2_kb_rx;

    localparam int DEPTH = 4;
    localparam int FILT  = 8;
    localparam int TMO   = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data_bus_o;
    logic       write_en_o;
    logic       write_ok_i = 1'b1;
    logic       frame_err_o;
    logic       ovf_o;
    logic [$clog2(DEPTH):0] fifo_cnt_o;

    int checks = 0;
    int errors = 0;
    int err_cyc = 0;
    int we_rises = 0;
    logic we_q = 1'b0;
    int e0;
    int w0;

    ps2_kb_rx #(
        .FIFO_DEPTH  (DEPTH),
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .data_bus_o  (data_bus_o),
        .write_en_o  (write_en_o),
        .write_ok_i  (write_ok_i),
        .frame_err_o (frame_err_o),
        .ovf_o       (ovf_o),
        .fifo_cnt_o  (fifo_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err_o) err_cyc++;
        if (write_en_o && !we_q) we_rises++;
        we_q = write_en_o;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cycles(10);
        ps2_clk = 1'b0;
        cycles(15);
        ps2_clk = 1'b1;
        cycles(15);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ flip);
        send_bit(1'b1);
    endtask

    // Acts as the driver: waits for a request, takes it, re-arms.
    task automatic get_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!write_en_o && n < 300) begin
            cycles(1);
            n++;
        end
        check({tag, "_we"}, int'(write_en_o), 1);
        check({tag, "_data"}, int'(data_bus_o), int'(exp));
        cycles(2);
        check({tag, "_hold"}, int'(data_bus_o), int'(exp));
        write_ok_i = 1'b0;
        cycles(1);
        check({tag, "_we_fall"}, int'(write_en_o), 0);
        write_ok_i = 1'b1;
        cycles(1);
    endtask

    initial begin
        cycles(3);
        check("rst_we", int'(write_en_o), 0);
        check("rst_err", int'(frame_err_o), 0);
        check("rst_ovf", int'(ovf_o), 0);
        check("rst_cnt", int'(fifo_cnt_o), 0);
        check("rst_bus", int'(data_bus_o), 0);
        rst = 1'b0;
        cycles(20);

        send_frame(8'h1C, 1'b0);
        get_byte("t1", 8'h1C);
        cycles(5);
        check("t1_cnt", int'(fifo_cnt_o), 0);

        e0 = err_cyc;
        w0 = we_rises;
        send_frame(8'h1C, 1'b1);
        cycles(20);
        check("t2_err", err_cyc - e0, 1);
        check("t2_we", we_rises - w0, 0);
        check("t2_cnt", int'(fifo_cnt_o), 0);

        write_ok_i = 1'b0;
        send_frame(8'h15, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h24, 1'b0);
        send_frame(8'h2D, 1'b0);
        check("t3_ovf_pre", int'(ovf_o), 0);
        send_frame(8'h2C, 1'b0);
        cycles(5);
        check("t3_cnt", int'(fifo_cnt_o), 4);
        check("t3_ovf", int'(ovf_o), 1);
        w0 = we_rises;
        write_ok_i = 1'b1;
        get_byte("t3a", 8'h15);
        get_byte("t3b", 8'h1D);
        get_byte("t3c", 8'h24);
        get_byte("t3d", 8'h2D);
        cycles(50);
        check("t3_cnt_end", int'(fifo_cnt_o), 0);
        check("t3_count", we_rises - w0, 4);

        e0 = err_cyc;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        cycles(TMO - 200);
        check("t4_early", err_cyc - e0, 0);
        begin
            int n = 0;
            while (err_cyc == e0 && n < 400) begin
                cycles(1);
                n++;
            end
        end
        check("t4_tmo", err_cyc - e0, 1);
        send_frame(8'h5A, 1'b0);
        get_byte("t4", 8'h5A);

        e0 = err_cyc;
        ps2_clk = 1'b0;
        cycles(FILT - 1);
        ps2_clk = 1'b1;
        cycles(30);
        check("t5_glitch", err_cyc - e0, 0);
        ps2_clk = 1'b0;
        cycles(FILT);
        ps2_clk = 1'b1;
        cycles(30);
        check("t5_fall", err_cyc - e0, 1);
        send_frame(8'h12, 1'b0);
        get_byte("t5", 8'h12);

        write_ok_i = 1'b0;
        send_frame(8'h33, 1'b0);
        send_frame(8'h44, 1'b0);
        send_frame(8'h55, 1'b0);
        write_ok_i = 1'b1;
        cycles(3);
        check("t6_we", int'(write_en_o), 1);
        check("t6_bus", int'(data_bus_o), 8'h33);
        check("t6_cnt", int'(fifo_cnt_o), 2);
        check("t6_ovf_pre", int'(ovf_o), 1);
        rst = 1'b1;
        cycles(1);
        check("t6_we_rst", int'(write_en_o), 0);
        check("t6_cnt_rst", int'(fifo_cnt_o), 0);
        check("t6_ovf_rst", int'(ovf_o), 0);
        rst = 1'b0;
        cycles(10);
        check("t6_idle", int'(write_en_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
